// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg
//   Shared types and constants for mem_lane_sequencer and its helpers:
//   the sequencer state enum, the lane-index width helper, access size codes
//   and reset values for the registered result fields.
package mem_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE,
        S_DRAIN
    } mem_seq_state_e;

    // Width of a lane index; a single-lane build still carries one bit.
    function automatic int lane_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam logic [2:0] SIZE_BYTE  = 3'd0;
    localparam logic [2:0] SIZE_HALF  = 3'd1;
    localparam logic [2:0] SIZE_WORD  = 3'd2;
    localparam logic [2:0] SIZE_DWORD = 3'd3;

    localparam logic RST_EXC_VALID = 1'b0;
    localparam logic RST_FLUSHED   = 1'b0;

endpackage

// File: rtl/mem_lane_sequencer_lane_pick.sv
// lane_pick
//   Combinational priority encoder over a lane mask.
//   i_first=1 : returns the lowest set lane.
//   i_first=0 : returns the lowest set lane strictly above i_cur.
//   Ports: i_mask (lane mask), i_cur (current lane), i_first (search from 0),
//          o_idx (selected lane), o_found (a lane was selected).
module lane_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_mask,
    input  logic [IW-1:0] i_cur,
    input  logic          i_first,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    // Scan from the top down so the last hit (the lowest qualifying lane) wins.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_mask[i] && (i_first || (i > int'(i_cur)))) begin
                o_idx   = IW'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_lane_sequencer.sv
// mem_lane_sequencer
//   Accepts an issue group of NUM_LANES memory micro-ops, serialises their
//   bus accesses in lane order on one request/response port, and hands the
//   whole group to writeback with a single valid/ready transfer. An exception
//   on a lane suppresses that lane and every younger lane.
//   Ports:
//     clk, reset (sync, active high), flush (squash current group)
//     in_*   : issue group handshake and per-lane fields (flat, lane 0 in LSBs)
//     req_*  : bus request, held until resp_addr_ok
//     resp_* : bus address/data acknowledgements and load data
//     out_*  : group result (retire mask, load data, oldest exception lane)
module mem_lane_sequencer
    import mem_seq_pkg::*;
#(
    parameter  int NUM_LANES = 2,
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    localparam int STRB_W    = DATA_W / 8,
    localparam int LW        = lane_w(NUM_LANES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_LANES-1:0]          in_mem_en,
    input  logic [NUM_LANES-1:0]          in_wr,
    input  logic [NUM_LANES-1:0]          in_except,
    input  logic [NUM_LANES*ADDR_W-1:0]   in_addr,
    input  logic [NUM_LANES*3-1:0]        in_size,
    input  logic [NUM_LANES*STRB_W-1:0]   in_strobe,
    input  logic [NUM_LANES*DATA_W-1:0]   in_wdata,
    output logic                          req_valid,
    output logic [ADDR_W-1:0]             req_addr,
    output logic [2:0]                    req_size,
    output logic [STRB_W-1:0]             req_strobe,
    output logic [DATA_W-1:0]             req_data,
    input  logic                          resp_addr_ok,
    input  logic                          resp_data_ok,
    input  logic [DATA_W-1:0]             resp_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_LANES-1:0]          out_retire,
    output logic [NUM_LANES*DATA_W-1:0]   out_rdata,
    output logic                          out_exc_valid,
    output logic [LW-1:0]                 out_exc_lane
);

    mem_seq_state_e                   r_state;
    logic [LW-1:0]                    r_lane;
    logic                             r_flushed;
    logic [NUM_LANES-1:0]             r_active;
    logic [NUM_LANES-1:0]             r_wr;
    logic [NUM_LANES-1:0]             r_retire;
    logic [NUM_LANES-1:0][ADDR_W-1:0] r_addr;
    logic [NUM_LANES-1:0][2:0]        r_size;
    logic [NUM_LANES-1:0][STRB_W-1:0] r_strobe;
    logic [NUM_LANES-1:0][DATA_W-1:0] r_wdata;
    logic [NUM_LANES-1:0][DATA_W-1:0] r_rdata;
    logic                             r_exc_valid;
    logic [LW-1:0]                    r_exc_lane;

    logic                             w_exc_found;
    logic [LW-1:0]                    w_exc_idx;
    logic [NUM_LANES-1:0]             w_below_exc;
    logic [NUM_LANES-1:0]             w_in_active;
    logic                             w_first_found;
    logic [LW-1:0]                    w_first_idx;
    logic                             w_next_found;
    logic [LW-1:0]                    w_next_idx;
    logic                             w_flush_pend;
    logic                             w_lane_wr;

    // Oldest exception lane on the incoming group.
    lane_pick #(.N(NUM_LANES), .IW(LW)) u_pick_exc (
        .i_mask (in_except),
        .i_cur  ('0),
        .i_first(1'b1),
        .o_idx  (w_exc_idx),
        .o_found(w_exc_found)
    );

    always_comb begin
        w_below_exc = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_below_exc[i] = !w_exc_found || (i < int'(w_exc_idx));
        end
    end

    assign w_in_active = in_mem_en & w_below_exc;

    // First bus lane of a new group.
    lane_pick #(.N(NUM_LANES), .IW(LW)) u_pick_first (
        .i_mask (w_in_active),
        .i_cur  ('0),
        .i_first(1'b1),
        .o_idx  (w_first_idx),
        .o_found(w_first_found)
    );

    // Next bus lane after the one currently in flight.
    lane_pick #(.N(NUM_LANES), .IW(LW)) u_pick_next (
        .i_mask (r_active),
        .i_cur  (r_lane),
        .i_first(1'b0),
        .o_idx  (w_next_idx),
        .o_found(w_next_found)
    );

    // A flush seen while the request is still unacknowledged is remembered,
    // because the request itself cannot be withdrawn.
    assign w_flush_pend = flush || r_flushed;
    assign w_lane_wr    = r_wr[r_lane];

    assign in_ready   = (r_state == S_IDLE) && !flush && !reset;
    assign req_valid  = (r_state == S_REQ);
    assign req_addr   = req_valid ? r_addr[r_lane] : '0;
    assign req_size   = req_valid ? r_size[r_lane] : '0;
    assign req_strobe = (req_valid && w_lane_wr) ? r_strobe[r_lane] : '0;
    assign req_data   = (req_valid && w_lane_wr) ? r_wdata[r_lane] : '0;

    assign out_valid     = (r_state == S_DONE);
    assign out_retire    = r_retire;
    assign out_rdata     = r_rdata;
    assign out_exc_valid = r_exc_valid;
    assign out_exc_lane  = r_exc_lane;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_lane      <= '0;
            r_flushed   <= RST_FLUSHED;
            r_active    <= '0;
            r_wr        <= '0;
            r_retire    <= '0;
            r_addr      <= '0;
            r_size      <= {NUM_LANES{SIZE_BYTE}};
            r_strobe    <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_exc_valid <= RST_EXC_VALID;
            r_exc_lane  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && !flush) begin
                        r_active    <= w_in_active;
                        r_wr        <= in_wr;
                        r_addr      <= in_addr;
                        r_size      <= in_size;
                        r_strobe    <= in_strobe;
                        r_wdata     <= in_wdata;
                        r_rdata     <= '0;
                        r_retire    <= w_below_exc;
                        r_exc_valid <= w_exc_found;
                        r_exc_lane  <= w_exc_found ? w_exc_idx : '0;
                        r_flushed   <= 1'b0;
                        r_lane      <= w_first_idx;
                        r_state     <= w_first_found ? S_REQ : S_DONE;
                    end
                end
                S_REQ: begin
                    if (flush) begin
                        r_flushed <= 1'b1;
                    end
                    if (resp_addr_ok) begin
                        if (w_flush_pend) begin
                            r_flushed <= 1'b0;
                            r_state   <= resp_data_ok ? S_IDLE : S_DRAIN;
                        end else if (resp_data_ok) begin
                            if (!w_lane_wr) begin
                                r_rdata[r_lane] <= resp_data;
                            end
                            if (w_next_found) begin
                                r_lane <= w_next_idx;
                            end
                            r_state <= w_next_found ? S_REQ : S_DONE;
                        end else begin
                            r_state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    // A flush coinciding with data_ok closes the transaction here.
                    if (flush) begin
                        r_state <= resp_data_ok ? S_IDLE : S_DRAIN;
                    end else if (resp_data_ok) begin
                        if (!w_lane_wr) begin
                            r_rdata[r_lane] <= resp_data;
                        end
                        if (w_next_found) begin
                            r_lane <= w_next_idx;
                        end
                        r_state <= w_next_found ? S_REQ : S_DONE;
                    end
                end
                S_DONE: begin
                    if (flush || out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (resp_data_ok) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lane_sequencer.sv
module tb_mem_lane_sequencer;

    typedef struct {
        logic [3:0]   retire;
        logic [127:0] rdata;
        logic         exc_v;
        logic [1:0]   exc_lane;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic        clk = 1'b0;
    logic        reset, flush, out_ready;
    logic        resp_addr_ok, resp_data_ok;
    logic [31:0] resp_data;

    // Two-lane instance
    logic        in_valid, in_ready;
    logic [1:0]  in_mem_en, in_wr, in_except;
    logic [63:0] in_addr, in_wdata;
    logic [5:0]  in_size;
    logic [7:0]  in_strobe;
    logic        req_valid;
    logic [31:0] req_addr, req_data;
    logic [2:0]  req_size;
    logic [3:0]  req_strobe;
    logic        out_valid, out_exc_valid;
    logic [1:0]  out_retire;
    logic [63:0] out_rdata;
    logic [0:0]  out_exc_lane;

    // Four-lane instance
    logic         b_in_valid, b_in_ready;
    logic [3:0]   b_mem_en, b_wr, b_except;
    logic [127:0] b_addr, b_wdata;
    logic [11:0]  b_size;
    logic [15:0]  b_strobe;
    logic         b_req_valid;
    logic [31:0]  b_req_addr, b_req_data;
    logic [2:0]   b_req_size;
    logic [3:0]   b_req_strobe;
    logic         b_out_valid, b_exc_valid;
    logic [3:0]   b_out_retire;
    logic [127:0] b_out_rdata;
    logic [1:0]   b_exc_lane;

    always #5 clk = ~clk;

    mem_lane_sequencer #(.NUM_LANES(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mem_en(in_mem_en), .in_wr(in_wr), .in_except(in_except),
        .in_addr(in_addr), .in_size(in_size), .in_strobe(in_strobe), .in_wdata(in_wdata),
        .req_valid(req_valid), .req_addr(req_addr), .req_size(req_size),
        .req_strobe(req_strobe), .req_data(req_data),
        .resp_addr_ok(resp_addr_ok), .resp_data_ok(resp_data_ok), .resp_data(resp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_retire(out_retire),
        .out_rdata(out_rdata), .out_exc_valid(out_exc_valid), .out_exc_lane(out_exc_lane)
    );

    mem_lane_sequencer #(.NUM_LANES(4), .ADDR_W(32), .DATA_W(32)) dut4 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_mem_en(b_mem_en), .in_wr(b_wr), .in_except(b_except),
        .in_addr(b_addr), .in_size(b_size), .in_strobe(b_strobe), .in_wdata(b_wdata),
        .req_valid(b_req_valid), .req_addr(b_req_addr), .req_size(b_req_size),
        .req_strobe(b_req_strobe), .req_data(b_req_data),
        .resp_addr_ok(resp_addr_ok), .resp_data_ok(resp_data_ok), .resp_data(resp_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_retire(b_out_retire),
        .out_rdata(b_out_rdata), .out_exc_valid(b_exc_valid), .out_exc_lane(b_exc_lane)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready_rise: got %b expected 1", in_ready);
        end
        checks++;
        if ({req_valid, out_valid, out_exc_valid, out_retire, out_exc_lane} !== 6'b0 || out_rdata !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rv=%b ov=%b ev=%b ret=%b el=%b rd=%h expected all 0",
                     req_valid, out_valid, out_exc_valid, out_retire, out_exc_lane, out_rdata);
        end
        checks++;
        if (b_out_valid !== 1'b0 || b_out_retire !== 4'h0 || b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_dut4: got ov=%b ret=%b rdy=%b expected 0 0 1", b_out_valid, b_out_retire, b_in_ready);
        end
    endtask

    // Both lanes load, zero-wait bus.
    task automatic test_two_loads(input logic [31:0] d0, input logic [31:0] d1);
        exp_t e;
        in_valid = 1'b1; in_mem_en = 2'b11; in_wr = 2'b00; in_except = 2'b00;
        in_addr = {32'h0000_0200, 32'h0000_0100}; in_size = 6'b010_010;
        in_strobe = 8'hFF; in_wdata = 64'h0;
        e.retire = 4'b0011; e.rdata = {64'h0, d1, d0}; e.exc_v = 1'b0; e.exc_lane = 2'd0;
        exp_q.push_back(e);
        resp_addr_ok = 1'b1; resp_data_ok = 1'b1; resp_data = d0;
        tick();                                   // accepted at t
        in_valid = 1'b0;
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h100 || req_strobe !== 4'h0 || req_size !== 3'd2) begin
            errors++;
            $display("FAIL two_loads_req0: got v=%b a=%h s=%h z=%0d expected 1 100 0 2", req_valid, req_addr, req_strobe, req_size);
        end
        tick();                                   // t+2
        resp_data = d1;
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h200) begin
            errors++; $display("FAIL two_loads_req1: got v=%b a=%h expected 1 200", req_valid, req_addr);
        end
        tick();                                   // t+3
        resp_addr_ok = 1'b0; resp_data_ok = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || req_valid !== 1'b0) begin
            errors++; $display("FAIL two_loads_latency: got ov=%b rv=%b expected 1 0", out_valid, req_valid);
        end
        tick();                                   // held without ready
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_retire !== e.retire[1:0] || out_rdata !== e.rdata[63:0] || out_exc_valid !== e.exc_v) begin
            errors++;
            $display("FAIL two_loads_result: got ov=%b ret=%b rd=%h ev=%b expected 1 %b %h %b",
                     out_valid, out_retire, out_rdata, out_exc_valid, e.retire[1:0], e.rdata[63:0], e.exc_v);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL two_loads_no_overlap: got in_ready=%b expected 0", in_ready);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL two_loads_handshake: got ov=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    // Lane 0 store with delayed data phase, then lane 1 load.
    task automatic test_store_load();
        exp_t e;
        in_valid = 1'b1; in_mem_en = 2'b11; in_wr = 2'b01; in_except = 2'b00;
        in_addr = {32'h0000_0304, 32'h0000_0300}; in_size = 6'b010_001;
        in_strobe = 8'hF3; in_wdata = {32'h5555_5555, 32'hAABB_CCDD};
        e.retire = 4'b0011; e.rdata = {64'h0, 32'h33, 32'h0}; e.exc_v = 1'b0; e.exc_lane = 2'd0;
        exp_q.push_back(e);
        tick();                                   // t+1
        in_valid = 1'b0;
        checks++;
        if (req_valid !== 1'b1 || req_strobe !== 4'b0011 || req_data !== 32'hAABB_CCDD || req_size !== 3'd1) begin
            errors++;
            $display("FAIL store_req: got v=%b s=%b d=%h z=%0d expected 1 0011 aabbccdd 1", req_valid, req_strobe, req_data, req_size);
        end
        resp_addr_ok = 1'b1;
        tick();                                   // t+2, RESP
        resp_addr_ok = 1'b0;
        checks++;
        if (req_valid !== 1'b0) begin
            errors++; $display("FAIL store_resp_wait: got req_valid=%b expected 0", req_valid);
        end
        tick();                                   // t+3
        resp_data_ok = 1'b1; resp_data = 32'hDEAD_BEEF;
        tick();                                   // t+4
        resp_data_ok = 1'b0;
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h304 || req_strobe !== 4'h0) begin
            errors++; $display("FAIL store_lane1_req: got v=%b a=%h s=%b expected 1 304 0000", req_valid, req_addr, req_strobe);
        end
        resp_addr_ok = 1'b1;
        tick();                                   // t+5
        resp_addr_ok = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL store_early_out: got out_valid=%b expected 0", out_valid);
        end
        resp_data_ok = 1'b1; resp_data = 32'h33;
        tick();                                   // t+6
        resp_data_ok = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_retire !== e.retire[1:0] || out_rdata !== e.rdata[63:0]) begin
            errors++;
            $display("FAIL store_result: got ov=%b ret=%b rd=%h expected 1 %b %h", out_valid, out_retire, out_rdata, e.retire[1:0], e.rdata[63:0]);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Exception on the oldest lane: no bus traffic, immediate result.
    task automatic test_except();
        exp_t e;
        in_valid = 1'b1; in_mem_en = 2'b11; in_wr = 2'b00; in_except = 2'b01;
        e.retire = 4'b0000; e.rdata = 128'h0; e.exc_v = 1'b1; e.exc_lane = 2'd0;
        exp_q.push_back(e);
        tick();
        in_valid = 1'b0; in_except = 2'b00;
        e = exp_q.pop_front();
        checks++;
        if (req_valid !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL except_timing: got rv=%b ov=%b expected 0 1", req_valid, out_valid);
        end
        checks++;
        if (out_exc_valid !== e.exc_v || out_exc_lane !== e.exc_lane[0:0] || out_retire !== e.retire[1:0] || out_rdata !== e.rdata[63:0]) begin
            errors++;
            $display("FAIL except_result: got ev=%b el=%0d ret=%b rd=%h expected %b %0d %b %h",
                     out_exc_valid, out_exc_lane, out_retire, out_rdata, e.exc_v, e.exc_lane[0:0], e.retire[1:0], e.rdata[63:0]);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Four lanes: only lane 1 reaches the bus, lane 3 carries the exception.
    task automatic test_four_lane();
        exp_t e;
        int nreq;
        int bad_addr;
        nreq = 0; bad_addr = 0;
        b_in_valid = 1'b1; b_mem_en = 4'b1010; b_wr = 4'b0000; b_except = 4'b1000;
        b_addr = {32'h43, 32'h42, 32'h41, 32'h40};
        e.retire = 4'b0111; e.rdata = {32'h0, 32'h0, 32'h5A, 32'h0}; e.exc_v = 1'b1; e.exc_lane = 2'd3;
        exp_q.push_back(e);
        resp_addr_ok = 1'b1; resp_data_ok = 1'b1; resp_data = 32'h5A;
        tick();
        b_in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (b_out_valid) break;
            if (b_req_valid) begin
                nreq++;
                if (b_req_addr !== 32'h41) bad_addr++;
            end
            tick();
        end
        resp_addr_ok = 1'b0; resp_data_ok = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (b_out_valid !== 1'b1) begin
            errors++; $display("FAIL four_lane_timeout: got out_valid=%b expected 1", b_out_valid);
        end
        checks++;
        if (nreq != 1 || bad_addr != 0) begin
            errors++; $display("FAIL four_lane_requests: got %0d reqs (%0d wrong addr) expected 1 (0)", nreq, bad_addr);
        end
        checks++;
        if (b_out_retire !== e.retire || b_out_rdata !== e.rdata || b_exc_valid !== e.exc_v || b_exc_lane !== e.exc_lane) begin
            errors++;
            $display("FAIL four_lane_result: got ret=%b rd=%h ev=%b el=%0d expected %b %h %b %0d",
                     b_out_retire, b_out_rdata, b_exc_valid, b_exc_lane, e.retire, e.rdata, e.exc_v, e.exc_lane);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Flush while the request waits for addr_ok, then drain.
    task automatic test_flush();
        int held;
        held = 0;
        in_valid = 1'b1; in_mem_en = 2'b01; in_wr = 2'b00; in_except = 2'b00;
        in_addr = {32'h0, 32'h0000_0500};
        tick();                                   // t+1
        in_valid = 1'b0;
        flush = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (req_valid === 1'b1 && req_addr === 32'h500) held++;
            tick();
            flush = 1'b0;
        end
        checks++;
        if (held != 3 || req_valid !== 1'b1) begin
            errors++; $display("FAIL flush_req_held: got %0d held cycles, rv=%b now, expected 3 and 1", held, req_valid);
        end
        resp_addr_ok = 1'b1;
        tick();                                   // DRAIN
        resp_addr_ok = 1'b0;
        checks++;
        if (req_valid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_drain: got rv=%b ov=%b rdy=%b expected 0 0 0", req_valid, out_valid, in_ready);
        end
        flush = 1'b1;                             // no extra effect while draining
        tick();
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_drain_hold: got in_ready=%b expected 0", in_ready);
        end
        resp_data_ok = 1'b1; resp_data = 32'hBAD0_BAD0;
        tick();
        resp_data_ok = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_idle: got rdy=%b ov=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    // Reset in RESP aborts the transaction; the next group runs normally.
    task automatic test_reset_in_resp();
        in_valid = 1'b1; in_mem_en = 2'b01; in_wr = 2'b00; in_except = 2'b00;
        in_addr = {32'h0, 32'h0000_0600};
        tick();
        in_valid = 1'b0;
        resp_addr_ok = 1'b1;
        tick();                                   // RESP
        resp_addr_ok = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({req_valid, out_valid, out_exc_valid, out_retire, out_exc_lane} !== 6'b0 || out_rdata !== 64'h0) begin
            errors++;
            $display("FAIL resp_reset_outputs: got rv=%b ov=%b ev=%b ret=%b el=%b rd=%h expected all 0",
                     req_valid, out_valid, out_exc_valid, out_retire, out_exc_lane, out_rdata);
        end
        resp_data_ok = 1'b1; resp_data = 32'hFEED_FACE;
        tick();
        resp_data_ok = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || req_valid !== 1'b0 || in_ready !== 1'b1 || out_rdata !== 64'h0) begin
            errors++;
            $display("FAIL resp_reset_late_data: got ov=%b rv=%b rdy=%b rd=%h expected 0 0 1 0", out_valid, req_valid, in_ready, out_rdata);
        end
        test_two_loads(32'h77, 32'h88);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        resp_addr_ok = 1'b0; resp_data_ok = 1'b0; resp_data = '0;
        in_valid = 1'b0; in_mem_en = '0; in_wr = '0; in_except = '0;
        in_addr = '0; in_size = '0; in_strobe = '0; in_wdata = '0;
        b_in_valid = 1'b0; b_mem_en = '0; b_wr = '0; b_except = '0;
        b_addr = '0; b_size = '0; b_strobe = '0; b_wdata = '0;

        test_reset();
        test_two_loads(32'h11, 32'h22);
        test_store_load();
        test_except();
        test_four_lane();
        test_flush();
        test_reset_in_resp();

        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_lane_sequencer.md
# mem_lane_sequencer

Parametrised successor to the dual-lane memory stage. Accepts an issue group of NUM_LANES memory micro-ops per handshake and serialises their data accesses in lane order onto one shared data-bus port. An exception in any lane suppresses that lane and all younger lanes. The group is presented to writeback as a single valid/ready transfer.

## Interface
Parameters:
- NUM_LANES, 2: lanes per issue group (1..8); lane 0 is oldest.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; strobe width STRB_W = DATA_W/8.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  squash the current group (pipeline redirect).
- in_valid  in  1  issue group valid.
- in_ready  out  1  block can accept a group.
- in_mem_en  in  NUM_LANES  lane performs a bus access.
- in_wr  in  NUM_LANES  access is a store (otherwise a load).
- in_except  in  NUM_LANES  lane already carries an exception.
- in_addr  in  NUM_LANES*ADDR_W  per-lane address.
- in_size  in  NUM_LANES*3  per-lane access size code.
- in_strobe  in  NUM_LANES*STRB_W  per-lane byte strobes.
- in_wdata  in  NUM_LANES*DATA_W  per-lane store data.
- req_valid  out  1  bus request valid.
- req_addr  out  ADDR_W  request address.
- req_size  out  3  request size code.
- req_strobe  out  STRB_W  byte strobes; all zero for loads.
- req_data  out  DATA_W  store data.
- resp_addr_ok  in  1  request accepted.
- resp_data_ok  in  1  data phase complete.
- resp_data  in  DATA_W  load data.
- out_valid  out  1  group result valid.
- out_ready  in  1  writeback accepts the group.
- out_retire  out  NUM_LANES  lanes that commit (oldest lanes before the first exception lane).
- out_rdata  out  NUM_LANES*DATA_W  per-lane load data; zero for non-load lanes.
- out_exc_valid  out  1  group contains an exception.
- out_exc_lane  out  $clog2(NUM_LANES) (minimum 1)  index of the oldest exception lane.

## Operation
- States: IDLE, REQ, RESP, DONE, DRAIN.
- Group acceptance:
  - in_ready = (state==IDLE) && !flush && !reset.
  - When in_valid && in_ready, all inputs are latched.
  - k = lowest lane with in_except set; k = NUM_LANES if no lane has it.
  - Active lanes are lanes below k with in_mem_en set.
  - out_retire = lanes below k; out_exc_valid = (k<NUM_LANES); out_exc_lane = k.
- After acceptance the next state is REQ on the lowest active lane, or DONE if no lane is active.
- REQ:
  - req_valid is held with the current lane's fields until resp_addr_ok.
  - addr_ok together with data_ok: capture data and advance.
  - addr_ok alone: go to RESP with req_valid=0.
- RESP: wait for resp_data_ok, capture data, advance.
- Advance: go to REQ on the next higher active lane; go to DONE if none remains.
- Load capture: out_rdata[lane] <= resp_data. Store lanes and non-active lanes read 0.
- DONE: out_valid is held with stable outputs until out_ready; on the handshake go to IDLE.
- Flush:
  - IDLE or DONE: go to IDLE next cycle; the out_valid handshake is not required.
  - REQ: req_valid stays held until addr_ok, because a request is never withdrawn. Then go to DRAIN, or to IDLE if data_ok arrives in the same cycle.
  - RESP: go to DRAIN.
  - DRAIN: wait for data_ok, discard the data, then go to IDLE.
  - A flush during DRAIN has no additional effect.
- Reset takes priority over flush. It aborts everything, including an outstanding bus transaction.

## Timing
- Reset values: state IDLE; req_valid, out_valid, out_retire, out_rdata, out_exc_valid and out_exc_lane are all 0; in_ready is 0 during reset and 1 in the first cycle after reset.
- Group accepted at cycle t: first req_valid at t+1. A group with no active lane gives out_valid at t+1.
- Zero-wait bus (addr_ok and data_ok in the same cycle as req_valid): each active lane costs 1 cycle. Two loads accepted at t give REQ at t+1 and t+2 and out_valid at t+3.
- in_ready rises the cycle after the out handshake. There is no accept/complete overlap.
- All outputs are registered or decoded from the state. There is no combinational path from resp_* to req_*, or from out_ready to in_ready.

## Structure
- Package mem_seq_pkg holds:
  - the state enum (mem_seq_state_e);
  - lane-index width helper and size-code constants;
  - default zero constants for outputs.
- Sub-module lane_pick: combinational priority encoder. Given a lane mask and the current index, it returns the next higher set lane and a found flag. It is used for both the first-lane pick and the advance step.

## Test plan
- Two loads, lanes 0 and 1, zero-wait bus with resp_data 0x11 then 0x22 -> out_valid at t+3, out_rdata = {0x22, 0x11}, out_retire = 2'b11.
- Lane 0 store with strobe 4'b0011 and lane 1 load; addr_ok at t+1 and data_ok at t+3 -> req_strobe 4'b0011 on the lane 0 request, lane 1 request starts at t+4, out_valid follows its data_ok.
- in_except = 2'b01 with both lanes memory ops -> no req_valid, out_valid at t+1, out_exc_valid = 1, out_exc_lane = 0, out_retire = 0.
- NUM_LANES = 4, in_mem_en = 4'b1010, in_except = 4'b1000 -> exactly one bus request (lane 1), out_retire = 4'b0111, out_exc_lane = 3.
- Flush in REQ while addr_ok is held low for 3 cycles -> req_valid stays high until addr_ok; DRAIN until data_ok; then IDLE with no out_valid, and in_ready rises the next cycle.
- Reset asserted in RESP -> next cycle all outputs are 0; a late data_ok is ignored; the next group is processed normally.
